// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_seq_ctrl_pkg: shared encodings for the sequencer (classes/ALU ops, subops, FSM states, exec kinds, instruction layout)
package cpu_seq_ctrl_pkg;
  typedef enum logic [1:0] {OP_ONE, OP_ADD, OP_SUB, OP_SWAP} alu_op_t;
  typedef enum logic [2:0] {SO_STORE, SO_LOAD, SO_STOP, SO_JUMP, SO_MSTORE, SO_INC, SO_DEC, SO_ILL} subop_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_OPND, S_JMP, S_HALT} state_t;
  typedef enum logic [2:0] {K_STORE, K_LOAD, K_STOP, K_JUMP, K_MSTORE, K_ALU, K_SWAP, K_NOP} kind_t;
  typedef struct packed {
    alu_op_t cls;
    subop_t subop;
    logic [2:0] r;
  } instr_t;
endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: memory, ALU and regfile/accumulator control bundle
//   master = sequencer (drives strobes/addresses), slave = datapath (returns mem_rdata, alu_flag_zero)
interface cpu_seq_ctrl_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd;
  logic mem_wr;
  logic [7:0] mem_rdata;
  logic alu_en;
  logic [1:0] alu_op;
  logic alu_a_sel;
  logic alu_flag_zero;
  logic [2:0] rf_addr;
  logic rf_we;
  logic acc_we;
  logic acc_src;
  modport master (
    output mem_addr, mem_rd, mem_wr, alu_en, alu_op, alu_a_sel, rf_addr, rf_we, acc_we, acc_src,
    input mem_rdata, alu_flag_zero
  );
  modport slave (
    input mem_addr, mem_rd, mem_wr, alu_en, alu_op, alu_a_sel, rf_addr, rf_we, acc_we, acc_src,
    output mem_rdata, alu_flag_zero
  );
endinterface

// File: rtl/cpu_seq_ctrl_decode.sv
// cpu_seq_ctrl_decode: combinational IR decode
//   ir -> is_alu (ADD/SUB/INC/DEC), alu_op, alu_a_sel (IR passthrough for ONE class), kind (EXEC behaviour)
module cpu_seq_ctrl_decode
  import cpu_seq_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_alu,
  output alu_op_t    alu_op,
  output logic       alu_a_sel,
  output kind_t      kind
);
  instr_t i;
  assign i = ir;
  // class-00 non-ALU subops share their encoding with kind_t, so they map by cast
  always_comb begin
    is_alu = i.cls == OP_ADD || i.cls == OP_SUB || (i.cls == OP_ONE && (i.subop == SO_INC || i.subop == SO_DEC));
    alu_op = i.cls;
    alu_a_sel = i.cls == OP_ONE;
    kind = is_alu ? K_ALU : i.cls == OP_SWAP ? K_SWAP : kind_t'(i.subop);
  end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU
//   clk, rst (async active-high), start (leave IDLE/HALT, fetch from RESET_PC)
//   bus: memory/ALU/regfile/accumulator strobes (master side)
//   pc, ir, busy, halted, illegal (sticky, cleared by rst/start): status
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cpu_seq_ctrl_if.master    bus,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_t state;
  kind_t kind;
  alu_op_t op;
  logic is_alu, a_sel, ex;
  cpu_seq_ctrl_decode u_dec (.ir(ir), .is_alu(is_alu), .alu_op(op), .alu_a_sel(a_sel), .kind(kind));
  assign ex = state == S_EXEC;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      ir <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          state <= S_FETCH;
          pc <= RESET_PC;
          illegal <= 1'b0;
        end
        S_FETCH: begin
          pc <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir <= bus.mem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (kind == K_NOP) illegal <= 1'b1;
          if (kind == K_JUMP) pc <= pc + 1'b1;
          state <= kind == K_ALU ? S_WB : kind == K_STOP ? S_HALT : kind == K_JUMP ? S_OPND : S_FETCH;
        end
        S_WB: state <= S_FETCH;
        S_OPND: state <= S_JMP;
        S_JMP: begin
          // ir[0] marks the jump as conditional on the ALU zero flag
          if (!ir[0] || bus.alu_flag_zero) pc <= ADDR_W'(bus.mem_rdata);
          state <= S_FETCH;
        end
      endcase
    end
  end
  assign bus.mem_addr = pc;
  assign bus.mem_rd = state == S_FETCH || (ex && kind == K_JUMP);
  assign bus.mem_wr = ex && kind == K_MSTORE;
  assign bus.alu_en = ex && is_alu;
  assign bus.alu_op = op;
  assign bus.alu_a_sel = a_sel;
  assign bus.rf_addr = ir[2:0];
  assign bus.rf_we = ex && (kind == K_STORE || kind == K_SWAP);
  // SWAP writes both sides at once; the datapath samples the old values
  assign bus.acc_we = (ex && (kind == K_LOAD || kind == K_SWAP)) || state == S_WB;
  assign bus.acc_src = ex;
  assign busy = state != S_IDLE && state != S_HALT;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: instruction-level model of the sequencer checked every cycle, plus hand-computed literals
module tb_cpu_seq_ctrl;
  typedef struct packed {
    logic [7:0] pc, ir, addr;
    logic rd, wr, en, rfwe, accwe, src, bsy, hlt, ill;
    logic [1:0] op;
    logic asel;
    logic [2:0] rf;
  } obs_t;
  typedef struct packed {
    obs_t v;
    obs_t m;
    logic fz;
  } exp_t;
  localparam logic T = 1'b1, F = 1'b0;
  logic clk, rst, start, busy, halted, illegal, active, seen;
  logic [7:0] pc, ir, m_ir;
  logic m_ill;
  logic [7:0] mem [256];
  exp_t q[$];
  exp_t e_cur;
  obs_t a_obs;
  obs_t lg [64];
  int cyc, total, passed;
  cpu_seq_ctrl_if #(.ADDR_W(8)) bus ();
  cpu_seq_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .ir(ir), .busy(busy), .halted(halted), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic exp_t rec(input logic [7:0] p, i, input logic rd, wr, en, rfwe, accwe, src, bsy, hlt, ill,
                               input logic [1:0] op, input logic asel, input logic [2:0] rf, input logic fz);
    rec.v = {p, i, p, rd, wr, en, rfwe, accwe, src, bsy, hlt, ill, op, asel, rf};
    rec.m = {16'hFFFF, {8{rd}}, 5'h1F, accwe, 3'b111, {3{en}}, {3{rfwe | wr | (accwe & src)}}};
    rec.fz = fz;
  endfunction
  // walk the program an instruction at a time, expanding each into its cycle-by-cycle outputs
  task automatic build(input logic [3:0] fzb);
    logic [7:0] p, p1, b;
    logic [1:0] c;
    logic [2:0] s, r;
    logic alu, jmp, stop;
    int nj;
    nj = 0;
    p = 8'h00;
    m_ill = F;
    q.delete();
    for (int n = 0; n < 20; n++) begin
      b = mem[p];
      c = b[7:6];
      s = b[5:3];
      r = b[2:0];
      p1 = p + 8'd1;
      alu = c == 2'd1 || c == 2'd2 || (c == 2'd0 && (s == 3'd5 || s == 3'd6));
      jmp = c == 2'd0 && s == 3'd3;
      stop = c == 2'd0 && s == 3'd2;
      q.push_back(rec(p, m_ir, T, F, F, F, F, F, T, F, m_ill, 2'd0, F, 3'd0, F));
      q.push_back(rec(p1, m_ir, F, F, F, F, F, F, T, F, m_ill, 2'd0, F, 3'd0, F));
      m_ir = b;
      q.push_back(rec(p1, b, jmp, c == 2'd0 && s == 3'd4, alu, (c == 2'd0 && s == 3'd0) || c == 2'd3,
                      (c == 2'd0 && s == 3'd1) || c == 2'd3, T, T, F, m_ill, c, c == 2'd0, r, F));
      if (c == 2'd0 && s == 3'd7) m_ill = T;
      if (stop) begin
        repeat (3) q.push_back(rec(p1, b, F, F, F, F, F, F, F, T, m_ill, 2'd0, F, 3'd0, F));
        return;
      end
      if (alu) q.push_back(rec(p1, b, F, F, F, F, T, F, T, F, m_ill, 2'd0, F, 3'd0, F));
      if (jmp) begin
        q.push_back(rec(p1 + 8'd1, b, F, F, F, F, F, F, T, F, m_ill, 2'd0, F, 3'd0, F));
        q.push_back(rec(p1 + 8'd1, b, F, F, F, F, F, F, T, F, m_ill, 2'd0, F, 3'd0, fzb[nj]));
        p = (!r[0] || fzb[nj]) ? mem[p1] : p1 + 8'd1;
        nj++;
      end else p = p1;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (active) begin
      a_obs = {pc, ir, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.alu_en, bus.rf_we, bus.acc_we, bus.acc_src,
               busy, halted, illegal, bus.alu_op, bus.alu_a_sel, bus.rf_addr};
      cyc++;
      if (cyc < 64) lg[cyc] = a_obs;
      if (q.size() > 0) begin
        e_cur = q.pop_front();
        bus.alu_flag_zero = e_cur.fz;
        chk($sformatf("cyc%0d", cyc), 64'(a_obs & e_cur.m), 64'(e_cur.v & e_cur.m));
      end else bus.alu_flag_zero = F;
    end else bus.alu_flag_zero = F;
  end
  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  endtask
  task automatic run(input logic [3:0] fzb, input int busy_pulse);
    build(fzb);
    cyc = 0;
    active = T;
    start = T;
    @(negedge clk);
    start = F;
    if (busy_pulse > 0) begin
      repeat (busy_pulse - 1) @(negedge clk);
      start = T;
      @(negedge clk);
      start = F;
    end
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    q.delete();
    active = F;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    total = 0;
    passed = 0;
    rst = T;
    start = F;
    active = F;
    m_ir = 8'h00;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_state", {pc, ir, busy, halted, illegal, bus.mem_rd, bus.mem_wr, bus.alu_en, bus.rf_we, bus.acc_we}, 64'd0);
    rst = F;
    @(negedge clk);
    // LOAD r1 ; ADD r2 ; STOP
    mem[0] = 8'h09; mem[1] = 8'h42; mem[2] = 8'h10;
    run(4'b0000, 0);
    chk("A_load", {lg[3].accwe, lg[3].src, lg[3].rf}, {2'b11, 3'd1});
    chk("A_add", {lg[6].en, lg[6].op, lg[7].accwe, lg[7].src}, 5'b10110);
    chk("A_halt", {lg[10].hlt, lg[11].hlt, lg[11].pc}, {2'b01, 8'h03});
    // INC ; DEC ; STOP
    clear_mem();
    mem[0] = 8'h28; mem[1] = 8'h30; mem[2] = 8'h10;
    run(4'b0000, 0);
    chk("B_inc", {lg[3].en, lg[3].op, lg[3].asel, lg[4].en, lg[4].accwe}, 6'b100101);
    chk("B_dec", {lg[7].en, lg[7].op, lg[7].asel, lg[8].en, lg[8].accwe}, 6'b100101);
    // conditional JUMP to 40, taken then not taken
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h40; mem[2] = 8'h10; mem[8'h40] = 8'h10;
    run(4'b0001, 0);
    chk("C_taken", {lg[3].rd, lg[3].addr, lg[5].pc, lg[6].pc, lg[9].pc}, {1'b1, 8'h01, 8'h02, 8'h40, 8'h41});
    run(4'b0000, 0);
    chk("C_fall", {lg[5].pc, lg[6].pc, lg[9].pc}, {8'h02, 8'h02, 8'h03});
    // NOP at FF wraps pc and sets illegal; second jump falls through to STOP
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'hFF; mem[2] = 8'h10; mem[8'hFF] = 8'h38;
    run(4'b0001, 0);
    chk("D_wrap", {lg[6].pc, lg[7].pc, lg[8].ill, lg[9].ill}, {8'hFF, 8'h00, 2'b01});
    repeat (4) @(negedge clk);
    chk("D_sticky", {illegal, halted}, 2'b11);
    // SWAP r3 ; STOP with a start pulse while busy
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h10;
    run(4'b0000, 2);
    chk("E_swap", {lg[1].ill, lg[3].rfwe, lg[3].accwe, lg[3].src, lg[3].rf}, {4'b0111, 3'd3});
    chk("E_end", {lg[7].hlt, lg[7].pc}, {1'b1, 8'h02});
    // reset asserted mid-EXEC of ADD
    clear_mem();
    mem[0] = 8'h42;
    start = T;
    @(negedge clk);
    start = F;
    repeat (2) @(negedge clk);
    chk("R_exec", {bus.alu_en, busy}, 2'b11);
    rst = T;
    #1;
    chk("R_async", {busy, pc, ir, illegal, bus.alu_en, bus.acc_we}, 64'd0);
    @(negedge clk);
    rst = F;
    seen = F;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.alu_en | bus.acc_we | busy;
    end
    chk("R_quiet", {seen, pc}, 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
